// File: rtl/hamming_stream_encoder_pkg.sv
// Shared Hamming sizing helpers, reused by the encoder and the matching decoder.
package hamming_stream_encoder_pkg;

    // Smallest P with 2**P >= k+P+1.
    function automatic int unsigned hamming_par_bits(input int unsigned k);
        int unsigned p;
        p = 0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (p == 0 && (32'd1 << i) >= k + i + 1) p = i;
        end
        return p;
    endfunction

    function automatic bit is_pow2(input int unsigned j);
        return (j != 0) && ((j & (j - 1)) == 0);
    endfunction

    function automatic int unsigned code_width(input int unsigned dw, input int unsigned secded);
        return dw + hamming_par_bits(dw) + secded;
    endfunction

    function automatic int unsigned pos_width(input int unsigned dw);
        return int'($clog2(dw + hamming_par_bits(dw) + 1));
    endfunction

    // Bit j set when Hamming position j is covered by parity bit 2**i.
    function automatic logic [63:0] cover_mask(input int unsigned i);
        logic [63:0] m;
        m = '0;
        for (int unsigned j = 1; j < 64; j++) begin
            m[j] = ((j >> i) & 32'd1) == 32'd1;
        end
        return m;
    endfunction

endpackage

// File: rtl/hamming_enc_core.sv
// Pure combinational Hamming encoder: data word to codeword, optional SECDED bit in code_o[0].
module hamming_enc_core
    import hamming_stream_encoder_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned SECDED = 0
) (
    input  logic [DATA_W-1:0]                    data_i,
    output logic [code_width(DATA_W, SECDED)-1:0] code_o
);
    localparam int unsigned P = hamming_par_bits(DATA_W);
    localparam int unsigned N = DATA_W + P;

    logic [N:1]   dpos;
    logic [P-1:0] par;
    logic [N-1:0] ham;

    // Position j lands at ham[N-j]; data fills non-power-of-two slots in ascending order.
    for (genvar j = 1; j <= N; j++) begin : g_pos
        if (is_pow2(j)) begin : g_par_pos
            assign dpos[j]   = 1'b0;
            assign ham[N-j]  = par[$clog2(j)];
        end else begin : g_data_pos
            assign dpos[j]   = data_i[j - $clog2(j + 1) - 1];
            assign ham[N-j]  = dpos[j];
        end
    end

    for (genvar i = 0; i < P; i++) begin : g_par
        localparam logic [63:0] Mask = cover_mask(i);
        assign par[i] = ^(dpos & Mask[N:1]);
    end

    if (SECDED != 0) begin : g_secded
        assign code_o = {ham, ^ham};
    end else begin : g_sec
        assign code_o = ham;
    end

endmodule

// File: rtl/hamming_stream_encoder.sv
// Two-stage valid/ready Hamming encoder with per-word single-bit error injection
// and a count of delivered codewords.
module hamming_stream_encoder
    import hamming_stream_encoder_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned SECDED = 0,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [DATA_W-1:0]                     data_in,
    input  logic                                  inj_en,
    input  logic [pos_width(DATA_W)-1:0]          inj_pos,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [code_width(DATA_W, SECDED)-1:0] code_out,
    output logic [CNT_W-1:0]                      word_cnt
);
    localparam int unsigned N      = DATA_W + hamming_par_bits(DATA_W);
    localparam int unsigned CODE_W = code_width(DATA_W, SECDED);
    localparam int unsigned POS_W  = pos_width(DATA_W);

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic              s1_inj_en_q, s1_inj_en_d;
    logic [POS_W-1:0]  s1_inj_pos_q, s1_inj_pos_d;
    logic              out_valid_q, out_valid_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              adv2;
    logic [CODE_W-1:0] enc_code;
    logic [CODE_W-1:0] flip_mask;

    hamming_enc_core #(
        .DATA_W (DATA_W),
        .SECDED (SECDED)
    ) u_core (
        .data_i (s1_data_q),
        .code_o (enc_code)
    );

    // Injection acts after encoding, so the overall parity bit reflects the clean word.
    for (genvar j = 1; j <= N; j++) begin : g_flip
        assign flip_mask[CODE_W-j] = s1_inj_en_q && (s1_inj_pos_q == POS_W'(j));
    end
    if (SECDED != 0) begin : g_flip_overall
        assign flip_mask[0] = s1_inj_en_q && (s1_inj_pos_q == '0);
    end

    assign adv2     = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || adv2;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_data_d    = s1_data_q;
        s1_inj_en_d  = s1_inj_en_q;
        s1_inj_pos_d = s1_inj_pos_q;
        out_valid_d  = out_valid_q;
        code_d       = code_q;
        cnt_d        = cnt_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d    = data_in;
                s1_inj_en_d  = inj_en;
                s1_inj_pos_d = inj_pos;
            end
        end
        if (adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) code_d = enc_code ^ flip_mask;
        end
        if (out_valid_q && out_ready) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_inj_en_q  <= 1'b0;
            s1_inj_pos_q <= '0;
            out_valid_q  <= 1'b0;
            code_q       <= '0;
            cnt_q        <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            s1_inj_en_q  <= s1_inj_en_d;
            s1_inj_pos_q <= s1_inj_pos_d;
            out_valid_q  <= out_valid_d;
            code_q       <= code_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign code_out  = code_q;
    assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_hamming_stream_encoder.sv
// Scoreboard bench: three DATA_W=4 variants share one input stream, a DATA_W=11 variant runs random traffic.
module tb_hamming_stream_encoder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Shared stream for the DATA_W=4 instances (a: SEC, b: SECDED, d: CNT_W=3)
    logic       in_valid, inj_en, out_ready;
    logic [3:0] data;
    logic [2:0] inj_pos;
    logic       a_in_ready, a_out_valid, b_in_ready, b_out_valid, d_in_ready, d_out_valid;
    logic [6:0] a_code, d_code;
    logic [7:0] b_code;
    logic [15:0] a_cnt, b_cnt;
    logic [2:0] d_cnt;

    logic        c_in_valid, c_inj_en, c_out_ready, c_in_ready, c_out_valid;
    logic [10:0] c_data;
    logic [3:0]  c_inj_pos;
    logic [14:0] c_code;
    logic [15:0] c_cnt;

    hamming_stream_encoder #(.DATA_W(4), .SECDED(0), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .data_in(data),
        .inj_en(inj_en), .inj_pos(inj_pos), .out_valid(a_out_valid), .out_ready(out_ready),
        .code_out(a_code), .word_cnt(a_cnt));

    hamming_stream_encoder #(.DATA_W(4), .SECDED(1), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .data_in(data),
        .inj_en(inj_en), .inj_pos(inj_pos), .out_valid(b_out_valid), .out_ready(out_ready),
        .code_out(b_code), .word_cnt(b_cnt));

    hamming_stream_encoder #(.DATA_W(4), .SECDED(0), .CNT_W(3)) dut_d (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready), .data_in(data),
        .inj_en(inj_en), .inj_pos(inj_pos), .out_valid(d_out_valid), .out_ready(out_ready),
        .code_out(d_code), .word_cnt(d_cnt));

    hamming_stream_encoder #(.DATA_W(11), .SECDED(0), .CNT_W(16)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .data_in(c_data),
        .inj_en(c_inj_en), .inj_pos(c_inj_pos), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .code_out(c_code), .word_cnt(c_cnt));

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] qa[$], qb[$], qc[$], qd[$];
    int ca, cb, cc;
    logic [2:0] cd;
    logic [15:0] exp_a, exp_b, exp_c;

    // Reference: parity bits are the binary syndrome of the set data positions.
    function automatic logic [15:0] model(input int dw, input logic [15:0] d, input bit secded,
                                          input bit inj, input int pos);
        int p, n, cw, k, syn;
        logic [16:1] h;
        logic [15:0] c;
        p = 1;
        while ((1 << p) < dw + p + 1) p++;
        n = dw + p;
        cw = n + int'(secded);
        h = '0;
        k = 0;
        syn = 0;
        for (int j = 1; j <= n; j++) begin
            if ((j & (j - 1)) != 0) begin
                h[j] = d[k];
                k++;
                if (h[j]) syn = syn ^ j;
            end
        end
        for (int i = 0; i < p; i++) h[1 << i] = syn[i];
        c = '0;
        for (int j = 1; j <= n; j++) c[cw - j] = h[j];
        if (secded) c[0] = ^h;
        if (inj) begin
            if (pos >= 1 && pos <= n) c[cw - pos] = ~c[cw - pos];
            else if (pos == 0 && secded) c[0] = ~c[0];
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Called just after a falling edge with inputs set; records transfers of the coming rising edge.
    task automatic tick(output bit xfer);
        #1;
        xfer = in_valid && a_in_ready;
        if (xfer) begin
            qa.push_back(exp_a);
            qd.push_back(exp_a);
            qb.push_back(exp_b);
        end
        if (c_in_valid && c_in_ready) qc.push_back(exp_c);
        if (a_out_valid && out_ready) begin
            if (qa.size() == 0) check("spurious_a", 16'(a_out_valid), 16'd0);
            else check("code_a", 16'(a_code), qa.pop_front());
            ca++;
        end
        if (b_out_valid && out_ready) begin
            if (qb.size() == 0) check("spurious_b", 16'(b_out_valid), 16'd0);
            else check("code_b", 16'(b_code), qb.pop_front());
            cb++;
        end
        if (d_out_valid && out_ready) begin
            if (qd.size() == 0) check("spurious_d", 16'(d_out_valid), 16'd0);
            else check("code_d", 16'(d_code), qd.pop_front());
            cd = cd + 3'd1;
        end
        if (c_out_valid && c_out_ready) begin
            if (qc.size() == 0) check("spurious_c", 16'(c_out_valid), 16'd0);
            else check("code_c", 16'(c_code), qc.pop_front());
            cc++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        c_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        qa.delete(); qb.delete(); qc.delete(); qd.delete();
        ca = 0; cb = 0; cc = 0; cd = '0;
        #1;
        check("rst_out_valid", 16'(a_out_valid), 16'd0);
        check("rst_code", 16'(b_code), 16'd0);
        check("rst_cnt", a_cnt, 16'd0);
        check("rst_in_ready", 16'(a_in_ready), 16'd1);
    endtask

    task automatic drain();
        bit x;
        in_valid = 1'b0;
        c_in_valid = 1'b0;
        out_ready = 1'b1;
        c_out_ready = 1'b1;
        for (int i = 0; i < 20 && (qa.size() + qb.size() + qc.size() + qd.size()) != 0; i++) tick(x);
        check("drain_left", 16'(qa.size() + qb.size() + qc.size() + qd.size()), 16'd0);
    endtask

    task automatic set_a(input logic [3:0] dv, input bit ie, input logic [2:0] ip);
        data = dv;
        inj_en = ie;
        inj_pos = ip;
        exp_a = model(4, 16'(dv), 1'b0, ie, int'(ip));
        exp_b = model(4, 16'(dv), 1'b1, ie, int'(ip));
    endtask

    typedef struct {
        logic [3:0] d;
        bit         ie;
        logic [2:0] ip;
        logic [6:0] ea;
        logic [7:0] eb;
    } vec_t;

    initial begin
        vec_t vecs[6];
        logic [3:0] words[5];
        bit x;
        int k;

        vecs[0] = '{4'b1011, 1'b0, 3'd0, 7'b1010101, 8'b10101010};
        vecs[1] = '{4'b0000, 1'b0, 3'd0, 7'b0000000, 8'b00000000};
        vecs[2] = '{4'b1011, 1'b1, 3'd0, 7'b1010101, 8'b10101011};
        vecs[3] = '{4'b1011, 1'b1, 3'd3, 7'b1000101, 8'b10001010};
        vecs[4] = '{4'b1011, 1'b1, 3'd7, 7'b1010100, 8'b10101000};
        vecs[5] = '{4'b1111, 1'b0, 3'd0, 7'b1111111, 8'b11111111};

        data = '0; inj_en = 1'b0; inj_pos = '0; out_ready = 1'b1;
        c_data = '0; c_inj_en = 1'b0; c_inj_pos = '0; c_out_ready = 1'b1;
        exp_a = '0; exp_b = '0; exp_c = '0;
        do_reset();

        // Directed vectors, back to back, with a latency check on the first word
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            data = vecs[i].d;
            inj_en = vecs[i].ie;
            inj_pos = vecs[i].ip;
            exp_a = 16'(vecs[i].ea);
            exp_b = 16'(vecs[i].eb);
            tick(x);
            if (i == 0) check("lat_1cyc", 16'(a_out_valid), 16'd0);
            if (i == 1) check("lat_2cyc", 16'(a_out_valid), 16'd1);
        end
        drain();

        // Random traffic on the DATA_W=4 group
        for (int i = 0; i < 200; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            set_a(4'($urandom), ($urandom_range(0, 3) == 0), 3'($urandom));
            tick(x);
        end
        drain();
        check("cnt_a_rand", a_cnt, 16'(ca));
        check("cnt_b_rand", b_cnt, 16'(cb));

        // Backpressure: five words against a six-cycle stall
        do_reset();
        for (int i = 0; i < 5; i++) words[i] = 4'($urandom);
        k = 0;
        for (int cyc = 0; cyc < 40 && (k < 5 || qa.size() != 0); cyc++) begin
            out_ready = (cyc >= 6);
            in_valid = (k < 5);
            if (k < 5) set_a(words[k], 1'b0, 3'd0);
            #1;
            if (cyc == 2) check("bp_in_ready", 16'(a_in_ready), 16'd0);
            if (cyc == 5) check("bp_hold_valid", 16'(a_out_valid), 16'd1);
            tick(x);
            if (x) k++;
        end
        check("bp_sent", 16'(k), 16'd5);
        drain();
        check("bp_cnt", a_cnt, 16'd5);

        // Reset with both stages full; stale words must not come back
        do_reset();
        out_ready = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 10 && k < 2; cyc++) begin
            in_valid = 1'b1;
            set_a(4'($urandom), 1'b0, 3'd0);
            tick(x);
            if (x) k++;
        end
        in_valid = 1'b0;
        #1;
        check("full_out_valid", 16'(a_out_valid), 16'd1);
        check("full_in_ready", 16'(a_in_ready), 16'd0);
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick(x);
        k = 0;
        for (int cyc = 0; cyc < 30 && k < 9; cyc++) begin
            in_valid = 1'b1;
            set_a(4'($urandom), 1'b0, 3'd0);
            tick(x);
            if (x) k++;
        end
        drain();
        check("wrap_cnt_d", 16'(d_cnt), 16'd1);
        check("cnt_a_9", a_cnt, 16'd9);

        // DATA_W=11 instance: all ones, then random words with injection and stalls
        c_in_valid = 1'b1;
        c_data = 11'h7FF;
        c_inj_en = 1'b0;
        exp_c = 16'h7FFF;
        tick(x);
        for (int i = 0; i < 1000; i++) begin
            c_in_valid = ($urandom_range(0, 4) != 0);
            c_out_ready = ($urandom_range(0, 3) != 0);
            c_data = 11'($urandom);
            c_inj_en = ($urandom_range(0, 3) == 0);
            c_inj_pos = 4'($urandom);
            exp_c = model(11, 16'(c_data), 1'b0, c_inj_en, int'(c_inj_pos));
            tick(x);
        end
        drain();
        check("cnt_c", c_cnt, 16'(cc));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
